// File: rtl/avc_read_sequencer.sv
// ---------------------------------------------------------------------------
// avc_read_sequencer
//
// Sequences one AVC1 read session: arms and kicks the reader datapath, counts
// received words, runs a progress watchdog, retries on error/timeout and
// finally holds a sticky PASS or FAIL status.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   start           single-cycle START pulse (ignored while busy or aborting)
//   abort           synchronous abort level, wins over everything else
//   rdr_ready       reader idle and able to accept a start
//   rdr_word_valid  one word captured this cycle
//   rdr_done        session completed OK (pulse)
//   rdr_err         datapath error (pulse)
//   rdr_en          reader enable
//   rdr_start       one-cycle start pulse to the reader
//   busy            session in progress
//   pass / fail     sticky result of the last session
//   timeout         final failure was a watchdog expiry (valid with fail)
//   attempt         0-based attempt index of current/last session
//   word_cnt        words received in the current/last attempt (saturating)
//
// All outputs come straight from flops; the output flops are loaded from the
// next-state value so they change on the same edge as the state register.
// ---------------------------------------------------------------------------
module avc_read_sequencer #(
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TIMEOUT = {TMO_W{1'b1}},
  parameter int               RETRIES = 2,
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             rdr_ready,
  input  logic             rdr_word_valid,
  input  logic             rdr_done,
  input  logic             rdr_err,
  output logic             rdr_en,
  output logic             rdr_start,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [2:0]       attempt,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_KICK,
    S_RUN,
    S_RETRY,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [2:0] RETRIES_L = 3'(RETRIES);

  state_t             state_q,     state_d;
  logic [TMO_W-1:0]   wdog_q,      wdog_d;
  logic [CNT_W-1:0]   word_cnt_q,  word_cnt_d;
  logic [2:0]         attempt_q,   attempt_d;
  logic               pass_q,      pass_d;
  logic               fail_q,      fail_d;
  logic               timeout_q,   timeout_d;
  logic               rdr_en_q,    rdr_en_d;
  logic               rdr_start_q, rdr_start_d;
  logic               busy_q,      busy_d;

  logic               wdog_expired;
  logic               give_up;      // attempt ended badly: retry or fail
  logic               give_up_tmo;  // ...and the cause was the watchdog

  assign wdog_expired = (wdog_q == TIMEOUT);

  // NOTE: every signal assigned in this block gets a default first so no
  // path leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    word_cnt_d  = word_cnt_q;
    attempt_d   = attempt_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    give_up     = 1'b0;
    give_up_tmo = 1'b0;

    if (abort) begin
      // Counters are held for debug; pass/fail keep whatever they had, which
      // is 0 for a session that was in flight.
      state_d = S_IDLE;
      wdog_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_ARM;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            attempt_d  = '0;
            word_cnt_d = '0;
            wdog_d     = '0;
          end
        end

        S_ARM: begin
          if (rdr_ready) begin
            state_d = S_KICK;
          end else if (wdog_expired) begin
            give_up     = 1'b1;
            give_up_tmo = 1'b1;
          end else begin
            wdog_d = wdog_q + TMO_W'(1);
          end
        end

        S_KICK: begin
          state_d    = S_RUN;
          wdog_d     = '0;
          word_cnt_d = '0;
        end

        S_RUN: begin
          // A word is counted even in the cycle that ends the attempt.
          if (rdr_word_valid) begin
            if (word_cnt_q != {CNT_W{1'b1}}) begin
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
            wdog_d = '0;
          end else if (!wdog_expired) begin
            wdog_d = wdog_q + TMO_W'(1);
          end

          if (rdr_done) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else if (rdr_err) begin
            give_up = 1'b1;
          end else if (!rdr_word_valid && wdog_expired) begin
            give_up     = 1'b1;
            give_up_tmo = 1'b1;
          end
        end

        S_RETRY: begin
          state_d   = S_ARM;
          attempt_d = attempt_q + 3'd1;
          wdog_d    = '0;
        end

        S_DONE:  state_d = S_IDLE;
        S_FAIL:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (give_up) begin
        if (attempt_q < RETRIES_L) begin
          state_d = S_RETRY;
        end else begin
          state_d   = S_FAIL;
          fail_d    = 1'b1;
          timeout_d = give_up_tmo;
        end
      end
    end
  end

  // Output flops follow the state being entered, keeping them aligned with
  // the state register without any input-to-output combinational path.
  always_comb begin
    rdr_en_d    = (state_d == S_ARM) || (state_d == S_KICK) || (state_d == S_RUN);
    rdr_start_d = (state_d == S_KICK);
    busy_d      = rdr_en_d || (state_d == S_RETRY);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wdog_q      <= '0;
      word_cnt_q  <= '0;
      attempt_q   <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rdr_en_q    <= 1'b0;
      rdr_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      word_cnt_q  <= word_cnt_d;
      attempt_q   <= attempt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      rdr_en_q    <= rdr_en_d;
      rdr_start_q <= rdr_start_d;
      busy_q      <= busy_d;
    end
  end

  assign rdr_en    = rdr_en_q;
  assign rdr_start = rdr_start_q;
  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign attempt   = attempt_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_avc_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_avc_read_sequencer
//
// Two sequencers share one stimulus stream:
//   dut_a : TIMEOUT=16, RETRIES=2, CNT_W=16
//   dut_b : TIMEOUT=16, RETRIES=1, CNT_W=3  (small counter to reach saturation)
// A session-level model predicts every output each cycle; directed literal
// checks pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_avc_read_sequencer;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, abort = 1'b0, rdr_ready = 1'b0;
  logic rdr_word_valid = 1'b0, rdr_done = 1'b0, rdr_err = 1'b0;

  logic        rdr_en_a, rdr_start_a, busy_a, pass_a, fail_a, timeout_a;
  logic [2:0]  attempt_a;
  logic [15:0] word_cnt_a;
  logic        rdr_en_b, rdr_start_b, busy_b, pass_b, fail_b, timeout_b;
  logic [2:0]  attempt_b;
  logic [2:0]  word_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avc_read_sequencer #(.TMO_W(16), .TIMEOUT(16'd16), .RETRIES(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .rdr_ready(rdr_ready),
    .rdr_word_valid(rdr_word_valid), .rdr_done(rdr_done), .rdr_err(rdr_err),
    .rdr_en(rdr_en_a), .rdr_start(rdr_start_a), .busy(busy_a), .pass(pass_a),
    .fail(fail_a), .timeout(timeout_a), .attempt(attempt_a), .word_cnt(word_cnt_a)
  );

  avc_read_sequencer #(.TMO_W(16), .TIMEOUT(16'd16), .RETRIES(1), .CNT_W(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .rdr_ready(rdr_ready),
    .rdr_word_valid(rdr_word_valid), .rdr_done(rdr_done), .rdr_err(rdr_err),
    .rdr_en(rdr_en_b), .rdr_start(rdr_start_b), .busy(busy_b), .pass(pass_b),
    .fail(fail_b), .timeout(timeout_b), .attempt(attempt_b), .word_cnt(word_cnt_b)
  );

  logic [24:0] vec_a, vec_b;
  assign vec_a = {rdr_en_a, rdr_start_a, busy_a, pass_a, fail_a, timeout_a, attempt_a, word_cnt_a};
  assign vec_b = {rdr_en_b, rdr_start_b, busy_b, pass_b, fail_b, timeout_b, attempt_b,
                  13'd0, word_cnt_b};

  // ---------------------------------------------------------------- model
  localparam int P_IDLE = 0, P_ARM = 1, P_KICK = 2, P_RUN = 3,
                 P_RETRY = 4, P_DONE = 5, P_FAIL = 6;

  typedef struct {
    int ph;    // session phase
    int att;   // attempt index
    int wc;    // words this attempt
    int idle;  // cycles since last progress
    bit pass;
    bit fail;
    bit tmo;
  } mstate_t;

  mstate_t m_a, m_b;

  function automatic mstate_t zero_state();
    mstate_t s;
    s.ph = P_IDLE; s.att = 0; s.wc = 0; s.idle = 0;
    s.pass = 1'b0; s.fail = 1'b0; s.tmo = 1'b0;
    return s;
  endfunction

  function automatic mstate_t end_attempt(mstate_t s, int retries, bit by_watchdog);
    mstate_t r = s;
    if (s.att < retries) begin
      r.ph = P_RETRY;
    end else begin
      r.ph   = P_FAIL;
      r.fail = 1'b1;
      r.tmo  = by_watchdog;
    end
    return r;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int retries, int cmax,
                                         bit st, bit ab, bit rdy, bit wv, bit dn, bit er);
    mstate_t r = s;
    if (ab) begin
      r.ph = P_IDLE;
      return r;
    end
    case (s.ph)
      P_IDLE: if (st) begin
        r = zero_state();
        r.ph = P_ARM;
      end
      P_ARM: begin
        if (rdy)                r.ph = P_KICK;
        else if (s.idle == TMO) r = end_attempt(s, retries, 1'b1);
        else                    r.idle = s.idle + 1;
      end
      P_KICK: begin
        r.ph = P_RUN; r.idle = 0; r.wc = 0;
      end
      P_RUN: begin
        if (wv) begin
          r.wc   = (s.wc + 1 > cmax) ? cmax : s.wc + 1;
          r.idle = 0;
        end else begin
          r.idle = s.idle + 1;
        end
        if (dn) begin
          r.ph = P_DONE; r.pass = 1'b1;
        end else if (er) begin
          r = end_attempt(r, retries, 1'b0);
        end else if (!wv && s.idle == TMO) begin
          r = end_attempt(r, retries, 1'b1);
        end
      end
      P_RETRY: begin
        r.ph = P_ARM; r.att = s.att + 1; r.idle = 0;
      end
      default: r.ph = P_IDLE;
    endcase
    return r;
  endfunction

  function automatic logic [24:0] exp_vec(mstate_t s);
    logic en, ks, bz;
    en = (s.ph == P_ARM) || (s.ph == P_KICK) || (s.ph == P_RUN);
    ks = (s.ph == P_KICK);
    bz = en || (s.ph == P_RETRY);
    return {en, ks, bz, s.pass, s.fail, s.tmo, 3'(s.att), 16'(s.wc)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a <= zero_state();
      m_b <= zero_state();
    end else begin
      m_a <= model_step(m_a, 2, 65535, start, abort, rdr_ready, rdr_word_valid, rdr_done, rdr_err);
      m_b <= model_step(m_b, 1, 7,     start, abort, rdr_ready, rdr_word_valid, rdr_done, rdr_err);
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_dut_a", 32'(vec_a), 32'(exp_vec(m_a)));
    check("model_dut_b", 32'(vec_b), 32'(exp_vec(m_b)));
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input bit st, input bit ab, input bit wv, input bit dn, input bit er);
    start = st; abort = ab; rdr_word_valid = wv; rdr_done = dn; rdr_err = er;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0; rdr_word_valid = 1'b0; rdr_done = 1'b0; rdr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // start pulse then two cycles: ARM -> KICK -> RUN (rdr_ready high)
  task automatic open_session();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
  endtask

  int n;

  initial begin
    #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    check("reset_state_a", 32'(vec_a), 32'd0);
    check("reset_state_b", 32'(vec_b), 32'd0);

    // ---- nominal: rdr_start in the third cycle counting the start cycle
    rdr_ready = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nom_arm", {29'd0, rdr_start_a, busy_a, rdr_en_a}, 32'b011);
    idle(1);
    check("nom_rdr_start", {30'd0, rdr_start_a, rdr_start_b}, 32'b11);
    idle(1);
    check("nom_start_one_cycle", {31'd0, rdr_start_a}, 32'd0);
    repeat (5) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("nom_word_cnt", {16'd0, word_cnt_a}, 32'd5);
    check("nom_result", {26'd0, pass_a, fail_a, busy_a, attempt_a}, {26'd0, 6'b100_000});
    idle(1);
    check("nom_pass_sticky", {31'd0, pass_a}, 32'd1);

    // ---- retry then success
    open_session();
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("retry_en_low", {30'd0, rdr_en_a, busy_a}, 32'b01);
    idle(1);
    check("retry_rearm", {28'd0, rdr_en_a, attempt_a}, {28'd0, 4'b1_001});
    idle(1);
    check("retry_second_kick", {31'd0, rdr_start_a}, 32'd1);
    idle(1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("retry_result", {25'd0, pass_a, attempt_a, word_cnt_a[2:0]}, {25'd0, 7'b1_001_001});
    idle(1);

    // ---- timeout exhaustion in RUN: watchdog values 0..16, expiry seen at 16
    open_session();
    n = 0;
    while (rdr_en_b && n < 100) begin idle(1); n++; end
    check("tmo_run_cycles", 32'(n), 32'(TMO + 1));
    idle(3);
    n = 0;
    while (!fail_b && n < 100) begin idle(1); n++; end
    check("tmo_b_cycles", 32'(n), 32'(TMO + 1));
    check("tmo_b_result", {26'd0, fail_b, timeout_b, busy_b, attempt_b}, {26'd0, 6'b110_001});
    n = 0;
    while (!fail_a && n < 100) begin idle(1); n++; end
    check("tmo_a_result", {27'd0, fail_a, timeout_a, attempt_a}, {27'd0, 5'b11_010});
    idle(1);

    // ---- watchdog expiry while waiting for rdr_ready in ARM
    rdr_ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (rdr_en_b && n < 100) begin idle(1); n++; end
    check("arm_tmo_cycles", 32'(n), 32'(TMO + 1));
    n = 0;
    while (!(fail_a && fail_b) && n < 200) begin idle(1); n++; end
    check("arm_tmo_result", {28'd0, fail_a, timeout_a, fail_b, timeout_b}, 32'b1111);
    rdr_ready = 1'b1;
    idle(1);

    // ---- error exhaustion: timeout flag must stay clear
    open_session();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("err_b_result", {27'd0, fail_b, timeout_b, attempt_b}, {27'd0, 5'b10_001});
    idle(3);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("err_a_result", {27'd0, fail_a, timeout_a, attempt_a}, {27'd0, 5'b10_010});
    idle(1);

    // ---- simultaneous events and start while busy
    open_session();
    repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("busy_start_ignored", {15'd0, rdr_start_a, word_cnt_a}, 32'd2);
    idle(1);
    check("busy_start_no_kick", {31'd0, rdr_start_a}, 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("simul_done", {14'd0, pass_a, fail_a, word_cnt_a}, {14'd0, 2'b10, 16'd3});
    idle(1);

    // ---- word counter saturation (dut_b has a 3-bit counter)
    open_session();
    repeat (9) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("sat_a", {16'd0, word_cnt_a}, 32'd9);
    check("sat_b", {29'd0, word_cnt_b}, 32'd7);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // ---- abort mid-RUN after 3 words
    open_session();
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_idle", {12'd0, rdr_en_a, busy_a, pass_a, fail_a, word_cnt_a}, 32'd3);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_beats_start", {30'd0, busy_a, busy_b}, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_after_abort", {15'd0, busy_a, word_cnt_a}, {15'd0, 1'b1, 16'd0});
    idle(2);

    // ---- asynchronous reset mid-RUN, checked between clock edges
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_reset_busy", {15'd0, busy_a, word_cnt_a}, {15'd0, 1'b1, 16'd1});
    #1 reset = 1'b1;
    #1;
    check("async_reset_a", 32'(vec_a), 32'd0);
    check("async_reset_b", 32'(vec_b), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
